// File: rtl/line_drawer_stream.sv
// Streaming Bresenham line rasteriser with clipping, dash patterning
// and output backpressure; one pixel per accepted output transfer.
module line_drawer_stream #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int DASH_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x1_in,
  input  logic [COORD_W-1:0] y1_in,
  input  logic [COORD_W-1:0] x2_in,
  input  logic [COORD_W-1:0] y2_in,
  input  logic [COLOR_W-1:0] color,
  input  logic [DASH_W-1:0]  dash_pattern,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_rts,
  input  logic               out_rtr,
  output logic               done
);

  localparam int EW = COORD_W + 2;
  localparam int IW = (DASH_W > 1) ? $clog2(DASH_W) : 1;

  localparam logic [COORD_W:0]   XLIM     = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0]   YLIM     = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
  localparam logic [IW-1:0]      IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]      IDX_LAST = IW'(DASH_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW
  } state_t;

  state_t state_q;

  logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
  logic [COLOR_W-1:0] col_q;
  logic [DASH_W-1:0]  pat_q;

  logic [COORD_W-1:0] cx_q, cy_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic sxn_q, syn_q;
  logic [IW-1:0] idx_q;
  logic live_q;

  logic [COORD_W-1:0] out_x_q, out_y_q;
  logic [COLOR_W-1:0] out_col_q;
  logic out_rts_q, in_rtr_q, done_q;

  logic [COORD_W-1:0] absx_d, absy_d;
  logic signed [EW-1:0] e2_d, err_d;
  logic stepx_d, stepy_d;
  logic [COORD_W-1:0] cx_d, cy_d;
  logic [IW-1:0] idx_d;
  logic vis_d, end_d, out_free;

  always_comb begin
    absx_d = (x2_q >= x1_q) ? x2_q - x1_q : x1_q - x2_q;
    absy_d = (y2_q >= y1_q) ? y2_q - y1_q : y1_q - y2_q;

    // Both step decisions use the pre-update error term.
    e2_d    = err_q <<< 1;
    stepx_d = (e2_d >= dy_q);
    stepy_d = (e2_d <= dx_q);

    err_d = err_q;
    if (stepx_d) err_d = err_d + dy_q;
    if (stepy_d) err_d = err_d + dx_q;

    cx_d = cx_q;
    if (stepx_d) cx_d = sxn_q ? cx_q - C_ONE : cx_q + C_ONE;
    cy_d = cy_q;
    if (stepy_d) cy_d = syn_q ? cy_q - C_ONE : cy_q + C_ONE;

    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;

    vis_d = ({1'b0, cx_q} <= XLIM) &&
            ({1'b0, cy_q} <= YLIM) &&
            pat_q[idx_q];
    end_d = (cx_q == x2_q) && (cy_q == y2_q);

    out_free = !out_rts_q || out_rtr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      col_q     <= '0;
      pat_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      sxn_q     <= 1'b0;
      syn_q     <= 1'b0;
      idx_q     <= '0;
      live_q    <= 1'b0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      out_col_q <= '0;
      out_rts_q <= 1'b0;
      in_rtr_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_rts && in_rtr_q) begin
            x1_q     <= x1_in;
            y1_q     <= y1_in;
            x2_q     <= x2_in;
            y2_q     <= y2_in;
            col_q    <= color;
            pat_q    <= dash_pattern;
            in_rtr_q <= 1'b0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          dx_q    <= $signed({2'b00, absx_d});
          dy_q    <= -$signed({2'b00, absy_d});
          err_q   <= $signed({2'b00, absx_d}) - $signed({2'b00, absy_d});
          sxn_q   <= (x2_q < x1_q);
          syn_q   <= (y2_q < y1_q);
          cx_q    <= x1_q;
          cy_q    <= y1_q;
          idx_q   <= '0;
          live_q  <= 1'b1;
          state_q <= DRAW;
        end
        DRAW: begin
          if (out_rts_q && out_rtr) out_rts_q <= 1'b0;
          // Generator advances only when the output slot frees up.
          if (live_q && out_free) begin
            if (vis_d) begin
              out_x_q   <= cx_q;
              out_y_q   <= cy_q;
              out_col_q <= col_q;
              out_rts_q <= 1'b1;
            end
            if (end_d) begin
              live_q <= 1'b0;
            end else begin
              err_q <= err_d;
              cx_q  <= cx_d;
              cy_q  <= cy_d;
              idx_q <= idx_d;
            end
          end else if (!live_q && out_free) begin
            done_q   <= 1'b1;
            in_rtr_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_rtr_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_rtr    = in_rtr_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_color = out_col_q;
  assign out_rts   = out_rts_q;
  assign done      = done_q;

endmodule

// File: tb/tb_line_drawer_stream.sv
// Randomised and directed bench for line_drawer_stream against an
// integer Bresenham reference model.
module tb_line_drawer_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x1_in, y1_in, x2_in, y2_in;
  logic [11:0] color;
  logic [15:0] dash_pattern;
  logic        in_rts;
  logic        in_rtr;
  logic [9:0]  out_x, out_y;
  logic [11:0] out_color;
  logic        out_rts;
  logic        out_rtr;
  logic        done;

  always #5 clk = ~clk;

  line_drawer_stream dut (
    .clk         (clk),
    .rst         (rst),
    .x1_in       (x1_in),
    .y1_in       (y1_in),
    .x2_in       (x2_in),
    .y2_in       (y2_in),
    .color       (color),
    .dash_pattern(dash_pattern),
    .in_rts      (in_rts),
    .in_rtr      (in_rtr),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_color   (out_color),
    .out_rts     (out_rts),
    .out_rtr     (out_rtr),
    .done        (done)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] c;
  } pix_t;

  int checks = 0;
  int errors = 0;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   first_k, last_k, done_k, done_cnt, hold_err, stray;
  bit   done_rtr, timeout;

  // Reference: walk the line with plain integers, keep visible pixels.
  task automatic model(input int x1, input int y1, input int x2,
                       input int y2, input logic [15:0] pat,
                       input logic [11:0] col);
    int dx, dy, sx, sy, err, e2, x, y, i;
    pix_t p;
    exp_q.delete();
    dx  = (x2 > x1) ? x2 - x1 : x1 - x2;
    dy  = -((y2 > y1) ? y2 - y1 : y1 - y2);
    sx  = (x2 >= x1) ? 1 : -1;
    sy  = (y2 >= y1) ? 1 : -1;
    err = dx + dy;
    x = x1;
    y = y1;
    i = 0;
    forever begin
      if (x <= 639 && y <= 479 && pat[i % 16]) begin
        p.x = 10'(x);
        p.y = 10'(y);
        p.c = col;
        exp_q.push_back(p);
      end
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
      i++;
    end
  endtask

  task automatic send(input int x1, input int y1, input int x2,
                      input int y2, input logic [15:0] pat,
                      input logic [11:0] col);
    int n = 0;
    @(negedge clk);
    while (!in_rtr && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rtr) begin
      errors++;
      $display("FAIL send_wait in_rtr got %0b exp 1", in_rtr);
    end
    x1_in = 10'(x1);
    y1_in = 10'(y1);
    x2_in = 10'(x2);
    y2_in = 10'(y2);
    color = col;
    dash_pattern = pat;
    in_rts = 1'b1;
    @(posedge clk);
    #1;
    in_rts = 1'b0;
    x1_in = 10'($urandom);
    y1_in = 10'($urandom);
    x2_in = 10'($urandom);
    y2_in = 10'($urandom);
    color = 12'($urandom);
    dash_pattern = 16'($urandom);
  endtask

  // mode 0: always ready, 1: 1,0,0 repeating, 2: random
  task automatic collect(input int mode);
    int k = 0;
    bit stall_prev = 0;
    logic [32:0] prev = '0;
    pix_t p;
    got_q.delete();
    first_k = -1; last_k = -1; done_k = -1;
    done_cnt = 0; hold_err = 0; stray = 0;
    done_rtr = 0; timeout = 0;
    forever begin
      @(negedge clk);
      out_rtr = (mode == 0) ? 1'b1 :
                (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      if (stall_prev && {out_rts, out_x, out_y, out_color} !== prev)
        hold_err++;
      if (done_k >= 0 && out_rts) stray++;
      if (out_rts && first_k < 0) first_k = k;
      if (out_rts && out_rtr) begin
        p.x = out_x;
        p.y = out_y;
        p.c = out_color;
        got_q.push_back(p);
        last_k = k;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          done_rtr = in_rtr;
        end
      end
      stall_prev = out_rts && !out_rtr;
      prev = {out_rts, out_x, out_y, out_color};
      k++;
      if (done_k >= 0 && k > done_k + 2) break;
      if (k > 3000) begin
        timeout = 1;
        break;
      end
    end
    out_rtr = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_rts = 1'b0;
    out_rtr = 1'b1;
    x1_in = '0; y1_in = '0; x2_in = '0; y2_in = '0;
    color = '0; dash_pattern = '0;
    #1;
    checks++;
    if (in_rtr !== 1'b1) begin
      errors++; $display("FAIL rst_in_rtr got %0b exp 1", in_rtr);
    end
    checks++;
    if (out_rts !== 1'b0) begin
      errors++; $display("FAIL rst_out_rts got %0b exp 0", out_rts);
    end
    checks++;
    if (out_x !== 10'd0 || out_y !== 10'd0) begin
      errors++; $display("FAIL rst_xy got %0d,%0d exp 0,0", out_x, out_y);
    end
    checks++;
    if (out_color !== 12'd0) begin
      errors++; $display("FAIL rst_color got %0h exp 0", out_color);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %0b exp 0", done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vertical;
    send(0, 4, 0, 0, 16'hFFFF, 12'hA5C);
    collect(0);
    model(0, 4, 0, 0, 16'hFFFF, 12'hA5C);
    checks++;
    if (got_q.size() !== 5) begin
      errors++; $display("FAIL vert_count got %0d exp 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].y !== 10'(4 - i)) begin
        errors++;
        $display("FAIL vert_pix%0d got %0d,%0d exp %0d,%0d", i,
                 got_q[i].x, got_q[i].y, exp_q[i].x, exp_q[i].y);
      end
    end
    checks++;
    if (first_k !== 2 || last_k !== 6) begin
      errors++;
      $display("FAIL vert_timing got first %0d last %0d exp 2 6",
               first_k, last_k);
    end
    checks++;
    if (done_cnt !== 1 || done_k !== 7) begin
      errors++;
      $display("FAIL vert_done got cnt %0d at %0d exp 1 at 7",
               done_cnt, done_k);
    end
    checks++;
    if (done_rtr !== 1'b1 || stray !== 0 || timeout) begin
      errors++;
      $display("FAIL vert_idle got rtr %0b stray %0d to %0b exp 1 0 0",
               done_rtr, stray, timeout);
    end
  endtask

  task automatic test_shallow;
    int ex[6] = '{0, 1, 2, 3, 4, 5};
    int ey[6] = '{0, 0, 1, 1, 2, 2};
    for (int dir = 0; dir < 2; dir++) begin
      if (dir == 0) send(0, 0, 5, 2, 16'hFFFF, 12'h123);
      else send(5, 2, 0, 0, 16'hFFFF, 12'h123);
      collect(0);
      checks++;
      if (got_q.size() !== 6 || done_cnt !== 1) begin
        errors++;
        $display("FAIL shallow%0d_count got %0d done %0d exp 6 1",
                 dir, got_q.size(), done_cnt);
      end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
        int j = (dir == 0) ? i : 5 - i;
        checks++;
        if (got_q[i].x !== 10'(ex[j]) || got_q[i].y !== 10'(ey[j]) ||
            got_q[i].c !== 12'h123) begin
          errors++;
          $display("FAIL shallow%0d_pix%0d got %0d,%0d exp %0d,%0d",
                   dir, i, got_q[i].x, got_q[i].y, ex[j], ey[j]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    send(0, 0, 3, 3, 16'hFFFF, 12'h7E7);
    collect(1);
    checks++;
    if (got_q.size() !== 4 || timeout) begin
      errors++;
      $display("FAIL bp_count got %0d exp 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i].x !== 10'(i) || got_q[i].y !== 10'(i)) begin
        errors++;
        $display("FAIL bp_pix%0d got %0d,%0d exp %0d,%0d",
                 i, got_q[i].x, got_q[i].y, i, i);
      end
    end
    checks++;
    if (hold_err !== 0) begin
      errors++; $display("FAIL bp_hold got %0d exp 0", hold_err);
    end
    checks++;
    if (done_cnt !== 1 || done_k !== last_k + 1) begin
      errors++;
      $display("FAIL bp_done got cnt %0d at %0d exp 1 at %0d",
               done_cnt, done_k, last_k + 1);
    end
  endtask

  task automatic test_clip_dash;
    send(636, 0, 643, 0, 16'hFFFF, 12'h0F0);
    collect(0);
    checks++;
    if (got_q.size() !== 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL clip_count got %0d done %0d exp 4 1",
               got_q.size(), done_cnt);
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i].x !== 10'(636 + i) || got_q[i].y !== 10'd0) begin
        errors++;
        $display("FAIL clip_pix%0d got %0d exp %0d", i, got_q[i].x, 636 + i);
      end
    end
    send(0, 0, 7, 0, 16'h5555, 12'h00F);
    collect(0);
    checks++;
    if (got_q.size() !== 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL dash_count got %0d done %0d exp 4 1",
               got_q.size(), done_cnt);
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i].x !== 10'(2 * i)) begin
        errors++;
        $display("FAIL dash_pix%0d got %0d exp %0d", i, got_q[i].x, 2 * i);
      end
    end
    send(0, 0, 0, 0, 16'h0000, 12'hFFF);
    collect(0);
    checks++;
    if (got_q.size() !== 0 || first_k !== -1 || done_cnt !== 1 || timeout) begin
      errors++;
      $display("FAIL nopix got %0d pix done %0d exp 0 1",
               got_q.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    send(0, 0, 9, 0, 16'hFFFF, 12'h321);
    out_rtr = 1'b1;
    @(negedge clk);
    while (!(out_rts && out_x == 10'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(out_rts && out_x == 10'd2)) begin
      errors++; $display("FAIL rmid_reach got x %0d exp 2", out_x);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_rts !== 1'b0 || in_rtr !== 1'b1) begin
      errors++;
      $display("FAIL rmid_state got rts %0b rtr %0b exp 0 1", out_rts, in_rtr);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_rts || done) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL rmid_quiet got %0d exp 0", n);
    end
    send(1, 1, 1, 1, 16'hFFFF, 12'h456);
    collect(0);
    checks++;
    if (got_q.size() !== 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL rmid_count got %0d done %0d exp 1 1",
               got_q.size(), done_cnt);
    end else begin
      checks++;
      if (got_q[0].x !== 10'd1 || got_q[0].y !== 10'd1 ||
          got_q[0].c !== 12'h456) begin
        errors++;
        $display("FAIL rmid_pix got %0d,%0d exp 1,1", got_q[0].x, got_q[0].y);
      end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      int x1, y1, x2, y2, mode;
      logic [15:0] pat;
      logic [11:0] col;
      x1 = $urandom_range(590, 690);
      y1 = $urandom_range(430, 520);
      x2 = x1 + $urandom_range(0, 70) - 35;
      y2 = y1 + $urandom_range(0, 70) - 35;
      pat = (t % 3 == 0) ? 16'hFFFF : 16'($urandom);
      col = 12'($urandom);
      mode = $urandom_range(0, 2);
      send(x1, y1, x2, y2, pat, col);
      collect(mode);
      model(x1, y1, x2, y2, pat, col);
      checks++;
      if (got_q.size() !== exp_q.size() || timeout) begin
        errors++;
        $display("FAIL rnd%0d_count got %0d exp %0d",
                 t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd%0d_pix%0d got %0d,%0d,%0h exp %0d,%0d,%0h",
                   t, i, got_q[i].x, got_q[i].y, got_q[i].c,
                   exp_q[i].x, exp_q[i].y, exp_q[i].c);
        end
      end
      checks++;
      if (done_cnt !== 1 || hold_err !== 0 || stray !== 0) begin
        errors++;
        $display("FAIL rnd%0d_ctl got done %0d hold %0d stray %0d exp 1 0 0",
                 t, done_cnt, hold_err, stray);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vertical();
    test_shallow();
    test_backpressure();
    test_clip_dash();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_drawer_stream.md
Name: line_drawer_stream

Overview:
Parametrised successor to the line drawer. Accepts one line command (two endpoints, colour, dash pattern) over an rts/rtr handshake. Rasterises the line with integer Bresenham and streams one pixel per accepted output transfer toward the framebuffer writer. Adds generic coordinate and colour widths, screen-bound clipping, dash patterning, output backpressure and a completion pulse.

Parameters:
COORD_W, 10, width of each x/y coordinate (unsigned)
COLOR_W, 12, pixel colour width
X_MAX, 639, largest visible x; pixels with x > X_MAX are clipped
Y_MAX, 479, largest visible y; pixels with y > Y_MAX are clipped
DASH_W, 16, dash pattern length in pixels

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
x1_in, y1_in  in  COORD_W each  start point
x2_in, y2_in  in  COORD_W each  end point
color  in  COLOR_W  line colour
dash_pattern  in  DASH_W  bit i=1 emits pixel index i mod DASH_W; all-ones gives a solid line
in_rts  in  1  command valid
in_rtr  out  1  ready for command
out_x, out_y  out  COORD_W each  pixel coordinate
out_color  out  COLOR_W  pixel colour
out_rts  out  1  pixel valid
out_rtr  in  1  downstream ready
done  out  1  one-cycle pulse when a command has fully completed

Behaviour:
- Reset values (asynchronous, all registers): state=IDLE, in_rtr=1, out_rts=0, out_x=out_y=0, out_color=0, done=0. Reset mid-draw abandons the line. No pixel is emitted after reset without a new command.
- States:
  - IDLE: in_rtr=1. Command is accepted on in_rts&&in_rtr; endpoints, colour and pattern are latched; in_rtr drops next cycle; go to SETUP.
  - SETUP (1 cycle): dx=|x2-x1|, dy=-|y2-y1|, sx=+1/-1 (x2>=x1 ? +1 : -1), sy likewise, err=dx+dy, cur=(x1,y1), idx=0; go to DRAW.
  - DRAW: evaluates the current pixel. Visible = (x<=X_MAX && y<=Y_MAX && dash_pattern[idx]).
    - If visible: out_rts=1 and out_x/out_y/out_color are driven. Pixel is consumed on out_rts&&out_rtr.
    - If not visible: pixel is consumed that cycle with out_rts=0.
    - On consume, if cur==(x2,y2): done=1 next cycle and return to IDLE.
    - Otherwise step. e2=2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both comparisons use the pre-update err. idx=(idx+1) mod DASH_W.
- Arithmetic: err and e2 are signed COORD_W+2 bits; no overflow for any COORD_W inputs.
- Pixel count per line = max(|dx|,|dy|)+1, endpoints inclusive. The sequence is emitted in order from (x1,y1) to (x2,y2).
- Latency: command accepted at edge N, SETUP at N+1, first pixel out_rts=1 after edge N+2. Unstalled throughput is one pixel per cycle.
- Backpressure: while out_rts=1 && out_rtr=0, out_x/out_y/out_color/out_rts are held stable and internal state is frozen.
- Degenerate line (x1==x2 && y1==y2): exactly one pixel, subject to clip and dash bit 0.
- Fully clipped or fully dashed-out line: no out_rts; done still pulses after the last index.
- done coincides with in_rtr returning to 1. A new command may be accepted on the same cycle done is high.
- in_rts is ignored while not in IDLE. Inputs may change freely after acceptance.

Test Plan:
- Vertical line (0,4)->(0,0), pattern 0xFFFF, out_rtr=1 -> pixels (0,4),(0,3),(0,2),(0,1),(0,0) on consecutive cycles starting edge N+2; single done pulse after (0,0); in_rtr=1.
- Shallow line (0,0)->(5,2), solid -> exactly (0,0),(1,0),(2,1),(3,1),(4,2),(5,2). Reversed (5,2)->(0,0) -> same set in reverse order.
- Backpressure: (0,0)->(3,3) with out_rtr toggling 1,0,0,1,... -> outputs held constant during stalls; 4 pixels (i,i), none duplicated or lost.
- Clip and dash:
  - (636,0)->(643,0) solid -> only x=636..639 emitted; done pulses.
  - (0,0)->(7,0) pattern 0x5555 -> x=0,2,4,6 only.
  - (0,0)->(0,0) pattern 0x0000 -> no pixels; done pulses.
- Reset mid-draw: assert rst during pixel 2 of (0,0)->(9,0) -> out_rts=0 and in_rtr=1 immediately after reset. The next command (1,1)->(1,1) yields the single pixel (1,1) only.
